// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// One-hot vectors are handled at the maximum supported width and cast by callers.
package ring_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } arb_state_e;

    localparam int unsigned MAX_N = 16;
    localparam int unsigned MAX_IDX_W = 4;

    // Binary index of a one-hot vector; zero for an all-zero input.
    function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Rotate a one-hot vector left by one within an n-bit ring.
    function automatic logic [MAX_N-1:0] rot1(input logic [MAX_N-1:0] v, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                r[(i + 1) % n] = v[i];
            end
        end
        return r;
    endfunction

    function automatic bit params_legal(input int unsigned n, input int unsigned quantum,
                                        input int unsigned cnt_w);
        return (n >= 2) && (n <= MAX_N) && (quantum >= 2) && (quantum <= 255) &&
               (cnt_w >= 1) && (cnt_w < 32) && ((64'd1 << cnt_w) > 64'(quantum));
    endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational ring-order pick: first set bit of (req & mask) at or after ptr, wrapping.
// The masked request is rotated so ptr lands at bit 0, priority-scanned, then rotated back.
module ring_rr_pick
    import ring_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] gnt
);

    logic [MAX_IDX_W-1:0] shamt;
    logic [2*N-1:0]       dbl;
    logic [2*N-1:0]       shifted;
    logic [N-1:0]         rot_req;
    logic [N-1:0]         first;
    logic [2*N-1:0]       back;

    always_comb begin
        shamt   = onehot2idx(MAX_N'(ptr));
        dbl     = {req & mask, req & mask};
        shifted = dbl >> shamt;
        rot_req = shifted[N-1:0];
        // Isolate the lowest set bit of the rotated request.
        first   = rot_req & (~rot_req + N'(1));
        back    = {{N{1'b0}}, first} << shamt;
        gnt     = back[N-1:0] | back[2*N-1:N];
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a per-grant time quantum.
// All outputs are registered; the pointer moves only when an owner departs.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned QUANTUM = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GNT,
    output logic                 GNT_VALID,
    output logic [$clog2(N)-1:0] GNT_IDX,
    output logic                 EXPIRE
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(QUANTUM - 1);

    if (!params_legal(N, QUANTUM, CNT_W)) begin : g_param_check
        $error("ring_rr_arbiter: illegal N/QUANTUM/CNT_W combination");
    end

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [N-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N-1:0]     pick_mask;
    logic [N-1:0]     pick_ptr;
    logic [N-1:0]     pick_gnt;
    logic [N-1:0]     owner_rot;
    logic             owner_req;
    logic             others_req;
    logic             at_limit;

    // In GRANT the pick already starts from the post-handover pointer and skips the owner.
    always_comb begin
        owner_rot = N'(rot1(MAX_N'(gnt_q), N));
        if (state_q == GRANT) begin
            pick_ptr  = owner_rot;
            pick_mask = ~gnt_q;
        end else begin
            pick_ptr  = ptr_q;
            pick_mask = '1;
        end
    end

    ring_rr_pick #(
        .N (N)
    ) u_pick (
        .req  (REQ),
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .gnt  (pick_gnt)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        expire_d = 1'b0;

        owner_req  = |(REQ & gnt_q);
        others_req = |(REQ & ~gnt_q);
        at_limit   = (cnt_q == CNT_LIMIT);

        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    gnt_d   = pick_gnt;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    // Release takes precedence over expiry.
                    ptr_d   = owner_rot;
                    gnt_d   = pick_gnt;
                    cnt_d   = '0;
                    state_d = (|pick_gnt) ? GRANT : IDLE;
                end else if (at_limit && others_req) begin
                    ptr_d    = owner_rot;
                    gnt_d    = pick_gnt;
                    cnt_d    = '0;
                    expire_d = 1'b1;
                end else if (!at_limit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        valid_d = |gnt_d;
        idx_d   = IDX_W'(onehot2idx(MAX_N'(gnt_d)));
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= N'(1);
            cnt_q    <= '0;
            expire_q <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
        end
    end

    assign GNT       = gnt_q;
    assign GNT_VALID = valid_q;
    assign GNT_IDX   = idx_q;
    assign EXPIRE    = expire_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter (N=4, QUANTUM=4): directed scenarios plus
// randomized traffic against an integer-level ownership model.
module tb_ring_rr_arbiter;

    localparam int N = 4;
    localparam int Q = 4;

    logic         CLK;
    logic         RESETN;
    logic [N-1:0] REQ;
    logic [N-1:0] GNT;
    logic         GNT_VALID;
    logic [1:0]   GNT_IDX;
    logic         EXPIRE;

    int vectors;
    int miscompares;

    // Reference model: owner index (-1 = idle), pointer index, hold count, expiry flag.
    int m_own;
    int m_ptr;
    int m_cnt;
    bit m_exp;

    ring_rr_arbiter #(
        .N       (N),
        .QUANTUM (Q),
        .CNT_W   (8)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .REQ       (REQ),
        .GNT       (GNT),
        .GNT_VALID (GNT_VALID),
        .GNT_IDX   (GNT_IDX),
        .EXPIRE    (EXPIRE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int m_pick(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_exp = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        logic [N-1:0] others;
        m_exp = 0;
        if (m_own < 0) begin
            m_own = m_pick(r, m_ptr, -1);
            m_cnt = 0;
        end else begin
            others = r;
            others[m_own] = 1'b0;
            if (!r[m_own]) begin
                m_ptr = (m_own + 1) % N;
                m_own = m_pick(r, m_ptr, m_own);
                m_cnt = 0;
            end else if (m_cnt == Q - 1 && others != 0) begin
                m_ptr = (m_own + 1) % N;
                m_own = m_pick(r, m_ptr, m_own);
                m_cnt = 0;
                m_exp = 1;
            end else if (m_cnt < Q - 1) begin
                m_cnt++;
            end
        end
    endtask

    // Drive REQ, take one rising edge, advance the model, then settle before sampling.
    task automatic apply(input logic [N-1:0] r);
        REQ = r;
        @(posedge CLK);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        REQ = '0;
        @(negedge CLK);
        RESETN = 1'b0;
        model_reset();
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        REQ = '0;
        RESETN = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        vectors++;
        if (GNT !== 4'b0000 || GNT_VALID !== 1'b0) begin
            $display("FAIL reset_held: GNT=%b VALID=%b want 0000/0", GNT, GNT_VALID);
            miscompares++;
        end
        RESETN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            apply(4'b0000);
            vectors++;
            if ({GNT, GNT_VALID, GNT_IDX, EXPIRE} !== 8'b0) begin
                $display("FAIL reset_idle c%0d: GNT=%b VALID=%b IDX=%0d EXP=%b want all 0",
                         c, GNT, GNT_VALID, GNT_IDX, EXPIRE);
                miscompares++;
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        apply(4'b0100);
        vectors++;
        if (GNT !== 4'b0100 || GNT_IDX !== 2'd2 || GNT_VALID !== 1'b1) begin
            $display("FAIL single_grant: GNT=%b IDX=%0d VALID=%b want 0100/2/1",
                     GNT, GNT_IDX, GNT_VALID);
            miscompares++;
        end
        for (int c = 0; c < 20; c++) begin
            apply(4'b0100);
            vectors++;
            if (GNT !== 4'b0100 || EXPIRE !== 1'b0) begin
                $display("FAIL single_hold c%0d: GNT=%b EXP=%b want 0100/0", c, GNT, EXPIRE);
                miscompares++;
            end
        end
        apply(4'b0000);
        vectors++;
        if (GNT !== 4'b0000 || GNT_VALID !== 1'b0) begin
            $display("FAIL single_drop: GNT=%b VALID=%b want 0000/0", GNT, GNT_VALID);
            miscompares++;
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] want;
        do_reset();
        // Cycle k of ownership: owner (k/Q)%N, expiry pulse at each handover.
        for (int k = 0; k < 24; k++) begin
            apply(4'b1111);
            want = '0;
            want[(k / Q) % N] = 1'b1;
            vectors++;
            if (GNT !== want || EXPIRE !== (k > 0 && k % Q == 0)) begin
                $display("FAIL rotation k%0d: GNT=%b EXP=%b want %b/%0b",
                         k, GNT, EXPIRE, want, (k > 0 && k % Q == 0));
                miscompares++;
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        apply(4'b0001);
        apply(4'b1001);
        apply(4'b1000);
        vectors++;
        if (GNT !== 4'b1000 || EXPIRE !== 1'b0 || GNT_IDX !== 2'd3) begin
            $display("FAIL release_handover: GNT=%b EXP=%b IDX=%0d want 1000/0/3",
                     GNT, EXPIRE, GNT_IDX);
            miscompares++;
        end
    endtask

    task automatic test_coincide();
        do_reset();
        apply(4'b0001);
        for (int c = 0; c < Q - 1; c++) apply(4'b0011);
        vectors++;
        if (GNT !== 4'b0001 || EXPIRE !== 1'b0) begin
            $display("FAIL coincide_pre: GNT=%b EXP=%b want 0001/0", GNT, EXPIRE);
            miscompares++;
        end
        apply(4'b0010);
        vectors++;
        if (GNT !== 4'b0010 || EXPIRE !== 1'b0) begin
            $display("FAIL coincide_handover: GNT=%b EXP=%b want 0010/0", GNT, EXPIRE);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(4'b0010);
        vectors++;
        if (GNT !== 4'b0010) begin
            $display("FAIL async_pre: GNT=%b want 0010", GNT);
            miscompares++;
        end
        #1 RESETN = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (GNT !== 4'b0000 || GNT_VALID !== 1'b0) begin
            $display("FAIL async_clear: GNT=%b VALID=%b want 0000/0", GNT, GNT_VALID);
            miscompares++;
        end
        #1 RESETN = 1'b1;
        apply(4'b0110);
        vectors++;
        if (GNT !== 4'b0010 || GNT_IDX !== 2'd1) begin
            $display("FAIL async_regrant: GNT=%b IDX=%0d want 0010/1", GNT, GNT_IDX);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = N'($urandom_range(0, 15));
            if (m_own >= 0 && $urandom_range(0, 3) != 0) r[m_own] = 1'b1;
            if ($urandom_range(0, 15) == 0) r = '0;
            apply(r);
            want = m_gnt();
            vectors++;
            if (GNT !== want || GNT_VALID !== (m_own >= 0) || EXPIRE !== m_exp ||
                GNT_IDX !== 2'((m_own < 0) ? 0 : m_own)) begin
                $display("FAIL random c%0d req=%b: GNT=%b VALID=%b IDX=%0d EXP=%b want %b/%0b/%0d/%0b",
                         c, r, GNT, GNT_VALID, GNT_IDX, EXPIRE, want, (m_own >= 0),
                         (m_own < 0) ? 0 : m_own, m_exp);
                miscompares++;
            end
            vectors++;
            if (!$onehot0(GNT)) begin
                $display("FAIL random_onehot c%0d: GNT=%b want one-hot or zero", c, GNT);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        REQ         = '0;
        RESETN      = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_release();
        test_coincide();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. a ring/shift-register datapath or its output port) between N requesters.
- Priority pointer is a one-hot ring that rotates one position past each departing owner, so service order matches ring-counter order.
- Enforces a per-grant time quantum so one requester cannot hold the resource indefinitely.
- Sits between requester logic and the shared resource's enable/select.

Parameters:
- N, 4, number of requesters (2..16).
- QUANTUM, 8, maximum consecutive cycles one owner holds the grant while others wait (2..255).
- CNT_W, 8, quantum counter width; must satisfy 2^CNT_W > QUANTUM.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- REQ  input  N  request vector; bit i high = requester i wants or keeps the resource.
- GNT  output  N  registered one-hot grant; all-zero when idle.
- GNT_VALID  output  1  OR of GNT, registered.
- GNT_IDX  output  clog2(N)  binary index of the owner; 0 when idle.
- EXPIRE  output  1  one-cycle pulse: the grant was revoked by quantum expiry.

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low (RESETN).
- Reset values: GNT=0, GNT_VALID=0, GNT_IDX=0, EXPIRE=0. Pointer PTR=one-hot bit 0. Counter CNT=0. State=IDLE.
- Reset asserted mid-grant clears the grant immediately (asynchronous). The first grant after deassertion uses PTR=bit 0.
- Pick function: scan REQ (with a mask applied) in ring order, starting at PTR and wrapping from N-1 to 0. Return the first set bit as one-hot, or none.
- State IDLE:
  - If any REQ bit is set, the next edge loads GNT=pick(REQ), CNT=0 and moves to GRANT.
  - Latency from REQ rising to GNT is exactly 1 cycle.
  - If no REQ bit is set, stay in IDLE.
- State GRANT, owner o:
  - Case a, release: REQ[o]=0. Next edge sets PTR=rot(o)(o+1 mod N).
    - If pick(REQ & ~GNT) is non-empty, grant it directly: no idle bubble, CNT=0.
    - Otherwise GNT=0 and go to IDLE.
    - GNT drops 1 cycle after REQ[o] falls.
  - Case b, expiry: REQ[o]=1, CNT==QUANTUM-1 and (REQ & ~GNT)!=0. Next edge sets PTR=rot(o), GNT=pick(REQ & ~GNT), CNT=0 and pulses EXPIRE=1 for that cycle.
  - Case c, hold: REQ[o]=1 and not case b. Keep GNT. CNT increments, saturating at QUANTUM-1.
    - If no other requester is pending at saturation, the owner keeps the grant.
    - Expiry then triggers on the first cycle another requester appears.
- Simultaneous events: if release and expiry conditions coincide, release wins and EXPIRE stays 0.
  - REQ bits that rise in the same cycle as a handover are eligible in that handover's pick.
- GNT is always one-hot or zero; never multi-hot. GNT_IDX and GNT_VALID are registered alongside GNT, with no combinational path from REQ.
- PTR is only ever one-hot. It updates only on release or expiry, never on a fresh grant from IDLE.
- N=1 degenerate: not supported; elaboration asserts N>=2.

Decomposition:
- Package ring_arb_pkg:
  - state enum {IDLE, GRANT};
  - functions onehot2idx and rot1 (one-hot rotate-left by 1);
  - parameter legality checks.
- Sub-module ring_rr_pick: purely combinational.
  - Inputs: req[N], mask[N], ptr[N]. Output: gnt[N] one-hot or 0.
  - Implemented as a double-width rotate-and-priority scan.
  - Instantiated once. All sequential logic stays in ring_rr_arbiter.

Test Plan (N=4, QUANTUM=4):
- Reset/idle: RESETN low, then high with REQ=0000 -> GNT=0000, GNT_VALID=0, GNT_IDX=0, EXPIRE=0 for 10 cycles.
- Single requester: REQ=0100 at cycle 0 -> GNT=0100, GNT_IDX=2 at cycle 1. Hold REQ 20 cycles -> GNT stays, EXPIRE never pulses. Drop REQ -> GNT=0000 next cycle.
- Rotation: REQ=1111 held -> grants 0001,0010,0100,1000,0001..., each lasting 4 cycles. EXPIRE pulses on each handover, with no idle cycle between grants.
- Release handover: owner 0001 drops REQ while REQ=1001 remains -> next cycle GNT=1000 (PTR=0010 skips to bit 3), EXPIRE=0.
- Release/expiry coincidence: owner drops REQ exactly at CNT=3 with others pending -> handover occurs, EXPIRE=0.
- Async reset mid-grant: GNT=0010, pulse RESETN low between edges -> GNT=0000 immediately. After release with REQ=0110 -> GNT=0010 (PTR reset to bit 0).
